bp_fe_mem_sched: RTL and testbench

Sequencer and arbiter in front of the FE memory stage (itlb + icache + pma pipeline). It shares the single mem-command port between the PC-gen fetch stream and the FE-queue maintenance stream (itlb fence, itlb fill, icache fence), and tracks the two in-flight fetch stages. It drives the poison line on redirects and on misses, and parks and replays a missed fetch once its itlb fill or icache refill completes.

---
 rtl/bp_fe_mem_sched.sv | 113 +++++++++++
 tb/tb_bp_fe_mem_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_mem_sched.sv
// Arbitrates the FE mem-command port between PC-gen fetches and maintenance ops,
// tracks the two in-flight fetch stages and parks/replays fetches that miss.
module bp_fe_mem_sched #(
  parameter int vaddr_width_p   = 39,
  parameter int payload_width_p = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       fetch_v_i,
  input  logic [vaddr_width_p-1:0]   fetch_vaddr_i,
  output logic                       fetch_yumi_o,

  input  logic                       maint_v_i,
  input  logic [1:0]                 maint_op_i,
  input  logic [payload_width_p-1:0] maint_payload_i,
  output logic                       maint_yumi_o,

  input  logic                       redirect_v_i,

  output logic                       mem_cmd_v_o,
  output logic [1:0]                 mem_cmd_op_o,
  output logic [vaddr_width_p-1:0]   mem_cmd_vaddr_o,
  output logic [payload_width_p-1:0] mem_cmd_payload_o,
  input  logic                       mem_cmd_yumi_i,
  output logic                       mem_poison_o,

  input  logic                       mem_resp_v_i,
  input  logic                       mem_resp_itlb_miss_i,
  input  logic                       mem_resp_icache_miss_i,
  input  logic                       mem_resp_fault_i,
  input  logic                       cache_req_complete_i,

  output logic                       fetch_resp_v_o,
  output logic [vaddr_width_p-1:0]   fetch_resp_vaddr_o
);

  typedef enum logic [1:0] {RUN, WAIT_FILL, WAIT_CACHE, REPLAY} state_e;

  localparam logic [1:0] OP_FETCH    = 2'd0;
  localparam logic [1:0] OP_TLB_FILL = 2'd2;

  state_e                     state_r;
  logic                       v1_r, v2_r;
  logic [vaddr_width_p-1:0]   vaddr1_r, vaddr2_r, replay_vaddr_r;

  logic resp_v, miss, waiting;
  logic sel_replay, sel_maint, sel_fetch, fetch_acc;
  logic unused_fault;

  // Faulting responses are delivered like good ones; the fault flag travels on
  // a separate path downstream and does not steer scheduling.
  assign unused_fault = mem_resp_fault_i;

  // A response without a stage-2 fetch behind it is ignored.
  assign resp_v       = mem_resp_v_i & v2_r;
  assign miss         = resp_v & (mem_resp_itlb_miss_i | mem_resp_icache_miss_i);
  assign mem_poison_o = redirect_v_i | miss;
  assign waiting      = (state_r == WAIT_FILL) | (state_r == WAIT_CACHE);

  // A redirect discards a pending replay; op 0 on the maint port is never issued.
  // New fetches are held back on a miss cycle so nothing younger overtakes the replay.
  assign sel_replay = (state_r == REPLAY) & ~redirect_v_i;
  assign sel_maint  = ~sel_replay & maint_v_i & (maint_op_i != OP_FETCH)
                    & ((~v1_r & ~v2_r) | waiting);
  assign sel_fetch  = ~sel_replay & ~sel_maint & fetch_v_i
                    & (((state_r == RUN) & ~miss) | redirect_v_i);

  assign mem_cmd_v_o       = sel_replay | sel_maint | sel_fetch;
  assign mem_cmd_op_o      = sel_maint ? maint_op_i : OP_FETCH;
  assign mem_cmd_vaddr_o   = sel_replay ? replay_vaddr_r
                           : (sel_fetch ? fetch_vaddr_i : '0);
  assign mem_cmd_payload_o = sel_maint ? maint_payload_i : '0;

  assign fetch_yumi_o = sel_fetch & mem_cmd_yumi_i;
  assign maint_yumi_o = sel_maint & mem_cmd_yumi_i;
  assign fetch_acc    = (sel_replay | sel_fetch) & mem_cmd_yumi_i;

  assign fetch_resp_v_o     = resp_v & ~miss & ~redirect_v_i;
  assign fetch_resp_vaddr_o = vaddr2_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r        <= RUN;
      v1_r           <= 1'b0;
      v2_r           <= 1'b0;
      vaddr1_r       <= '0;
      vaddr2_r       <= '0;
      replay_vaddr_r <= '0;
    end else begin
      // stage 1 -> stage 2: poison kills the older fetch, never the one accepted now
      v1_r     <= fetch_acc;
      v2_r     <= v1_r & ~mem_poison_o;
      vaddr2_r <= vaddr1_r;
      if (fetch_acc) vaddr1_r <= mem_cmd_vaddr_o;

      if (redirect_v_i) begin
        state_r <= RUN;
      end else if (miss) begin
        replay_vaddr_r <= vaddr2_r;
        state_r        <= mem_resp_itlb_miss_i ? WAIT_FILL : WAIT_CACHE;
      end else begin
        case (state_r)
          WAIT_FILL:  if (maint_yumi_o && (maint_op_i == OP_TLB_FILL)) state_r <= REPLAY;
          WAIT_CACHE: if (cache_req_complete_i) state_r <= REPLAY;
          REPLAY:     if (fetch_acc) state_r <= RUN;
          default:    state_r <= state_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_mem_sched.sv
// Bench for bp_fe_mem_sched: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of in-flight fetches and scheduler mode.
module tb_bp_fe_mem_sched;
  localparam int VW = 39;
  localparam int PW = 64;
  localparam int M_RUN = 0, M_WF = 1, M_WC = 2, M_RP = 3;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          fetch_v_i;
  logic [VW-1:0] fetch_vaddr_i;
  logic          fetch_yumi_o;
  logic          maint_v_i;
  logic [1:0]    maint_op_i;
  logic [PW-1:0] maint_payload_i;
  logic          maint_yumi_o;
  logic          redirect_v_i;
  logic          mem_cmd_v_o;
  logic [1:0]    mem_cmd_op_o;
  logic [VW-1:0] mem_cmd_vaddr_o;
  logic [PW-1:0] mem_cmd_payload_o;
  logic          mem_cmd_yumi_i;
  logic          mem_poison_o;
  logic          mem_resp_v_i;
  logic          mem_resp_itlb_miss_i;
  logic          mem_resp_icache_miss_i;
  logic          mem_resp_fault_i;
  logic          cache_req_complete_i;
  logic          fetch_resp_v_o;
  logic [VW-1:0] fetch_resp_vaddr_o;

  always #5 clk = ~clk;

  bp_fe_mem_sched #(.vaddr_width_p(VW), .payload_width_p(PW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .fetch_v_i(fetch_v_i), .fetch_vaddr_i(fetch_vaddr_i), .fetch_yumi_o(fetch_yumi_o),
    .maint_v_i(maint_v_i), .maint_op_i(maint_op_i), .maint_payload_i(maint_payload_i),
    .maint_yumi_o(maint_yumi_o), .redirect_v_i(redirect_v_i),
    .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_op_o(mem_cmd_op_o), .mem_cmd_vaddr_o(mem_cmd_vaddr_o),
    .mem_cmd_payload_o(mem_cmd_payload_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
    .mem_poison_o(mem_poison_o), .mem_resp_v_i(mem_resp_v_i),
    .mem_resp_itlb_miss_i(mem_resp_itlb_miss_i), .mem_resp_icache_miss_i(mem_resp_icache_miss_i),
    .mem_resp_fault_i(mem_resp_fault_i), .cache_req_complete_i(cache_req_complete_i),
    .fetch_resp_v_o(fetch_resp_v_o), .fetch_resp_vaddr_o(fetch_resp_vaddr_o)
  );

  typedef struct packed {logic [VW-1:0] va; int cyc;} ent_t;

  ent_t          q[$];
  int            mode;
  logic [VW-1:0] rep_va;
  int            cur;
  int            n_cmp, n_err;
  logic          spur, k_itlb, k_icache, k_fault;

  logic          obs_cmd_v, obs_fy, obs_my, obs_poi, obs_rv;
  logic [1:0]    obs_op;
  logic [VW-1:0] obs_va, obs_ra;
  logic [PW-1:0] obs_pl;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cur, act, exp);
    end
  endtask

  task automatic idle();
    fetch_v_i = 1'b0; fetch_vaddr_i = '0; maint_v_i = 1'b0; maint_op_i = 2'd0;
    maint_payload_i = '0; redirect_v_i = 1'b0; mem_cmd_yumi_i = 1'b1;
    cache_req_complete_i = 1'b0; spur = 1'b0; k_itlb = 1'b0; k_icache = 1'b0; k_fault = 1'b0;
  endtask

  // One clock: act as the mem stage, compare against the model, advance the model.
  task automatic tick();
    int            i1, i2, src;
    bit            rv, mis, ep, erv, acc, quiet;
    logic [1:0]    eop;
    logic [VW-1:0] eva, s2va;
    logic [PW-1:0] epl;
    i1 = -1; i2 = -1; s2va = '0;
    foreach (q[k]) begin
      if (q[k].cyc == cur - 2) begin i2 = k; s2va = q[k].va; end
      if (q[k].cyc == cur - 1) i1 = k;
    end
    mem_resp_v_i           = (i2 >= 0) || spur;
    mem_resp_itlb_miss_i   = mem_resp_v_i & k_itlb;
    mem_resp_icache_miss_i = mem_resp_v_i & k_icache;
    mem_resp_fault_i       = mem_resp_v_i & k_fault;
    @(negedge clk);
    obs_cmd_v = mem_cmd_v_o; obs_op = mem_cmd_op_o; obs_va = mem_cmd_vaddr_o;
    obs_pl = mem_cmd_payload_o; obs_fy = fetch_yumi_o; obs_my = maint_yumi_o;
    obs_poi = mem_poison_o; obs_rv = fetch_resp_v_o; obs_ra = fetch_resp_vaddr_o;

    rv    = mem_resp_v_i && (i2 >= 0);
    mis   = rv && (mem_resp_itlb_miss_i || mem_resp_icache_miss_i);
    ep    = redirect_v_i || mis;
    erv   = rv && !mis && !redirect_v_i;
    quiet = (q.size() == 0);
    src = 0;
    if (mode == M_RP && !redirect_v_i) src = 1;
    else if (maint_v_i && maint_op_i != 2'd0 && (quiet || mode == M_WF || mode == M_WC)) src = 2;
    else if (fetch_v_i && ((mode == M_RUN && !mis) || redirect_v_i)) src = 3;
    eop = (src == 2) ? maint_op_i : 2'd0;
    eva = (src == 1) ? rep_va : ((src == 3) ? fetch_vaddr_i : '0);
    epl = (src == 2) ? maint_payload_i : '0;
    acc = mem_cmd_yumi_i && (src == 1 || src == 3);

    if (!reset_i) begin
      check("cmd_v",      64'(obs_cmd_v), 64'(src != 0));
      check("cmd_op",     64'(obs_op),    64'(eop));
      check("cmd_vaddr",  64'(obs_va),    64'(eva));
      check("cmd_pay",    obs_pl,         epl);
      check("fetch_yumi", 64'(obs_fy),    64'((src == 3) && mem_cmd_yumi_i));
      check("maint_yumi", 64'(obs_my),    64'((src == 2) && mem_cmd_yumi_i));
      check("poison",     64'(obs_poi),   64'(ep));
      check("resp_v",     64'(obs_rv),    64'(erv));
      if (erv) check("resp_vaddr", 64'(obs_ra), 64'(s2va));
    end

    @(posedge clk);
    if (reset_i) begin
      q.delete(); mode = M_RUN; rep_va = '0;
    end else begin
      if (redirect_v_i) mode = M_RUN;
      else if (mis) begin
        mode   = mem_resp_itlb_miss_i ? M_WF : M_WC;
        rep_va = s2va;
      end else if (mode == M_WF && src == 2 && mem_cmd_yumi_i && maint_op_i == 2'd2) mode = M_RP;
      else if (mode == M_WC && cache_req_complete_i) mode = M_RP;
      else if (mode == M_RP && acc) mode = M_RUN;
      if (ep && i1 >= 0) q.delete(i1);
      if (i2 >= 0) q.delete(i2);
      if (acc) q.push_back('{va: eva, cyc: cur});
    end
    cur++;
    #1;
  endtask

  initial begin
    bit            acc_flag;
    logic [63:0]   r64;
    n_cmp = 0; n_err = 0; cur = 0; mode = M_RUN; rep_va = '0;
    idle(); reset_i = 1'b1;
    mem_resp_v_i = 1'b0; mem_resp_itlb_miss_i = 1'b0;
    mem_resp_icache_miss_i = 1'b0; mem_resp_fault_i = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    reset_i = 1'b0; mem_cmd_yumi_i = 1'b0;
    tick();
    check("rst_cmd_v", 64'(obs_cmd_v), 64'd0);
    check("rst_poison", 64'(obs_poi), 64'd0);
    check("rst_resp_v", 64'(obs_rv), 64'd0);

    // Streaming
    idle(); fetch_v_i = 1'b1;
    fetch_vaddr_i = 39'h1000; tick(); check("s_yumi0", 64'(obs_fy), 64'd1);
    acc_flag = obs_poi;
    fetch_vaddr_i = 39'h1004; tick(); acc_flag |= obs_poi;
    fetch_vaddr_i = 39'h1008; tick(); acc_flag |= obs_poi;
    check("s_rv0", 64'(obs_rv), 64'd1); check("s_ra0", 64'(obs_ra), 64'h1000);
    fetch_v_i = 1'b0;
    tick(); acc_flag |= obs_poi; check("s_ra1", 64'(obs_ra), 64'h1004);
    tick(); acc_flag |= obs_poi; check("s_ra2", 64'(obs_ra), 64'h1008);
    check("s_rv2", 64'(obs_rv), 64'd1);
    check("s_no_poison", 64'(acc_flag), 64'd0);

    // Itlb miss with a younger fetch in stage 1
    idle(); fetch_v_i = 1'b1;
    fetch_vaddr_i = 39'h2000; tick();
    fetch_vaddr_i = 39'h2004; tick();
    fetch_vaddr_i = 39'h2008; k_itlb = 1'b1; tick();
    check("i_poison", 64'(obs_poi), 64'd1); check("i_yumi", 64'(obs_fy), 64'd0);
    k_itlb = 1'b0; tick();
    check("i_wf_yumi", 64'(obs_fy), 64'd0); check("i_wf_rv", 64'(obs_rv), 64'd0);
    fetch_v_i = 1'b0; maint_v_i = 1'b1; maint_op_i = 2'd2; maint_payload_i = 64'hDEAD_BEEF_0000_0001;
    tick();
    check("i_fill_yumi", 64'(obs_my), 64'd1); check("i_fill_pay", obs_pl, 64'hDEAD_BEEF_0000_0001);
    maint_v_i = 1'b0; fetch_v_i = 1'b1; fetch_vaddr_i = 39'h2abc; tick();
    check("i_rep_va", 64'(obs_va), 64'h2000); check("i_rep_op", 64'(obs_op), 64'd0);
    check("i_rep_fy", 64'(obs_fy), 64'd0);
    fetch_v_i = 1'b0; tick(); tick();
    check("i_rep_rv", 64'(obs_rv), 64'd1); check("i_rep_ra", 64'(obs_ra), 64'h2000);

    // Icache miss, hold, refill complete, replay
    idle(); fetch_v_i = 1'b1; fetch_vaddr_i = 39'h3000; tick();
    fetch_v_i = 1'b0; tick();
    k_icache = 1'b1; tick(); check("c_poison", 64'(obs_poi), 64'd1);
    k_icache = 1'b0; acc_flag = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); acc_flag |= obs_cmd_v; end
    check("c_hold", 64'(acc_flag), 64'd0);
    cache_req_complete_i = 1'b1; tick();
    cache_req_complete_i = 1'b0; tick();
    check("c_rep_v", 64'(obs_cmd_v), 64'd1); check("c_rep_va", 64'(obs_va), 64'h3000);
    tick(); tick(); check("c_rep_ra", 64'(obs_ra), 64'h3000);
    fetch_v_i = 1'b1; fetch_vaddr_i = 39'h3100; tick(); check("c_run", 64'(obs_fy), 64'd1);
    fetch_v_i = 1'b0; tick(); tick();

    // Maintenance waits for empty stages, then beats a pending fetch
    idle(); fetch_v_i = 1'b1; fetch_vaddr_i = 39'h5000; tick();
    fetch_vaddr_i = 39'h5004; tick();
    fetch_v_i = 1'b0; maint_v_i = 1'b1; maint_op_i = 2'd1; maint_payload_i = 64'h55;
    tick(); check("m_wait0", 64'(obs_my), 64'd0);
    tick(); check("m_wait1", 64'(obs_my), 64'd0);
    fetch_v_i = 1'b1; fetch_vaddr_i = 39'h5008; tick();
    check("m_issue", 64'(obs_my), 64'd1); check("m_op", 64'(obs_op), 64'd1);
    check("m_fetch_held", 64'(obs_fy), 64'd0);
    maint_v_i = 1'b0; tick(); check("m_fetch_go", 64'(obs_fy), 64'd1);
    fetch_v_i = 1'b0; tick(); tick();

    // Redirect during WAIT_CACHE with the redirect target fetched the same cycle
    idle(); fetch_v_i = 1'b1; fetch_vaddr_i = 39'h6000; tick();
    fetch_v_i = 1'b0; tick();
    k_icache = 1'b1; tick();
    k_icache = 1'b0; tick();
    redirect_v_i = 1'b1; fetch_v_i = 1'b1; fetch_vaddr_i = 39'h4000; tick();
    check("r_yumi", 64'(obs_fy), 64'd1); check("r_va", 64'(obs_va), 64'h4000);
    redirect_v_i = 1'b0; fetch_v_i = 1'b0; cache_req_complete_i = 1'b1; tick();
    cache_req_complete_i = 1'b0; tick();
    check("r_rv", 64'(obs_rv), 64'd1); check("r_ra", 64'(obs_ra), 64'h4000);
    tick(); check("r_no_replay", 64'(obs_cmd_v), 64'd0);

    // Reset while a replay is pending
    idle(); fetch_v_i = 1'b1; fetch_vaddr_i = 39'h7000; tick();
    fetch_v_i = 1'b0; tick();
    k_itlb = 1'b1; tick();
    k_itlb = 1'b0; maint_v_i = 1'b1; maint_op_i = 2'd2; tick();
    maint_v_i = 1'b0; mem_cmd_yumi_i = 1'b0; tick();
    check("x_replay_v", 64'(obs_cmd_v), 64'd1); check("x_replay_va", 64'(obs_va), 64'h7000);
    reset_i = 1'b1; tick();
    reset_i = 1'b0; spur = 1'b1; k_itlb = 1'b1; tick();
    check("x_cmd_v", 64'(obs_cmd_v), 64'd0); check("x_op", 64'(obs_op), 64'd0);
    check("x_va", 64'(obs_va), 64'd0); check("x_pay", obs_pl, 64'd0);
    check("x_fy", 64'(obs_fy), 64'd0); check("x_my", 64'(obs_my), 64'd0);
    check("x_poison", 64'(obs_poi), 64'd0); check("x_rv", 64'(obs_rv), 64'd0);
    check("x_ra", 64'(obs_ra), 64'd0);
    idle(); fetch_v_i = 1'b1; fetch_vaddr_i = 39'h7100; tick();
    check("x_run", 64'(obs_fy), 64'd1); check("x_run_va", 64'(obs_va), 64'h7100);
    fetch_v_i = 1'b0; tick(); tick();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      reset_i              = ($urandom_range(0, 299) == 0);
      fetch_v_i            = ($urandom_range(0, 9) < 8);
      r64                  = {$urandom, $urandom};
      fetch_vaddr_i        = r64[VW-1:0];
      maint_v_i            = ($urandom_range(0, 99) < 15);
      maint_op_i           = 2'($urandom_range(1, 3));
      maint_payload_i      = {$urandom, $urandom};
      redirect_v_i         = ($urandom_range(0, 99) < 5);
      mem_cmd_yumi_i       = ($urandom_range(0, 9) < 8);
      cache_req_complete_i = ($urandom_range(0, 9) == 0);
      k_itlb               = ($urandom_range(0, 9) == 0);
      k_icache             = ($urandom_range(0, 9) == 0);
      k_fault              = ($urandom_range(0, 4) == 0);
      spur                 = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
